// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the pipeline IF/MEM stages, the arbiter and the memory macro.
// slave: the arbiter's view; master: the pipeline/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_be, mem_addr,
           mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_be, mem_addr,
           mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has fixed priority; one access in flight, sequenced against MEM_LAT.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state;
  logic [2:0] cnt;
  logic       kill;

  logic capture;
  logic kill_now;
  logic d_elig;
  logic i_elig;
  logic grant_d;
  logic grant_i;

  // A requester whose done is high this cycle still shows a stale req; mask it.
  // A completing requester is also excluded at the back-to-back slot unless its fetch was killed.
  always_comb begin
    capture  = (state != IDLE) && (cnt == 3'd0);
    kill_now = kill | bus.if_flush;
    d_elig   = bus.d_req & ~bus.d_done & (state != BUSY_D);
    i_elig   = bus.if_req & ~bus.if_done & ~bus.if_flush & ((state != BUSY_I) | kill);
    grant_d  = ((state == IDLE) | capture) & d_elig;
    grant_i  = ((state == IDLE) | capture) & i_elig & ~d_elig;
  end

  assign bus.stall_if  = bus.if_req & ~bus.if_done & ~bus.if_flush;
  assign bus.stall_mem = bus.d_req & ~bus.d_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      kill          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_done   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_done    <= 1'b0;
    end else begin
      bus.mem_en  <= 1'b0;
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;

      if (state == BUSY_I && bus.if_flush) kill <= 1'b1;
      if (state != IDLE && cnt != 3'd0) cnt <= cnt - 3'd1;

      if (capture) begin
        if (state == BUSY_I && !kill_now) begin
          bus.if_rdata <= bus.mem_rdata;
          bus.if_done  <= 1'b1;
        end
        if (state == BUSY_D) begin
          bus.d_done <= 1'b1;
          if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
        end
        state <= IDLE;
        kill  <= 1'b0;
      end

      // Grant overrides the capture's IDLE/kill updates for the back-to-back slot.
      if (grant_d) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_be    <= bus.d_be;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        state         <= BUSY_D;
        cnt           <= LAT;
      end else if (grant_i) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_be    <= '1;
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= '0;
        state         <= BUSY_I;
        cnt           <= LAT;
        kill          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a negedge-driven memory model.
module tb_mem_port_arbiter;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0593 : (32'hC000_0000 | a);
  endfunction

  // Read data is valid only in the second half of cycle 1+LAT; otherwise poison.
  int unsigned pcnt  = 0;
  logic [31:0] paddr = '0;
  always @(negedge clk) begin
    bus.mem_rdata = 32'hDEAD_BEEF;
    if (bus.mem_en === 1'b1) begin
      pcnt  = LAT;
      paddr = bus.mem_addr;
    end else if (pcnt != 0) begin
      pcnt = pcnt - 1;
      if (pcnt == 0) bus.mem_rdata = mem_word(paddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.if_req   = 1'b0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req  = 1'b1; bus.d_addr  = 32'h100;
    for (int c = 0; c < 2; c++) begin
      step();
      nvec++;
      if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.if_done,
           bus.d_done, bus.if_rdata, bus.d_rdata} !== '0) begin
        nerr++;
        $display("FAIL reset_outputs cyc%0d got en=%b addr=%h ifd=%b dd=%b want all 0",
                 c, bus.mem_en, bus.mem_addr, bus.if_done, bus.d_done);
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      nvec++;
      if (bus.mem_en !== 1'b0) begin
        nerr++; $display("FAIL reset_release_en cyc%0d got %b want 0", c, bus.mem_en);
      end
    end
  endtask

  task automatic test_fetch();
    for (int c = 0; c <= 5; c++) begin
      bus.if_req = (c <= 4); bus.if_addr = 32'h10;
      #1;
      nvec++;
      if (bus.mem_en !== (c == 1)) begin
        nerr++; $display("FAIL fetch_mem_en c%0d got %b want %b", c, bus.mem_en, (c == 1));
      end
      nvec++;
      if (bus.if_done !== (c == 4)) begin
        nerr++; $display("FAIL fetch_if_done c%0d got %b want %b", c, bus.if_done, (c == 4));
      end
      nvec++;
      if (bus.stall_if !== (c <= 3)) begin
        nerr++; $display("FAIL fetch_stall_if c%0d got %b want %b", c, bus.stall_if, (c <= 3));
      end
      if (c == 1) begin
        nvec++;
        if (bus.mem_addr !== 32'h10) begin
          nerr++; $display("FAIL fetch_mem_addr got %h want 00000010", bus.mem_addr);
        end
      end
      if (c == 4) begin
        nvec++;
        if (bus.if_rdata !== 32'h0050_0593) begin
          nerr++; $display("FAIL fetch_if_rdata got %h want 00500593", bus.if_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c <= 8; c++) begin
      bus.if_req = (c <= 7); bus.if_addr = 32'h14;
      bus.d_req  = (c <= 4); bus.d_we = 1'b0; bus.d_addr = 32'h100;
      #1;
      nvec++;
      if (bus.mem_en !== (c == 1 || c == 4)) begin
        nerr++; $display("FAIL simul_mem_en c%0d got %b want %b", c, bus.mem_en, (c == 1 || c == 4));
      end
      nvec++;
      if (bus.d_done !== (c == 4)) begin
        nerr++; $display("FAIL simul_d_done c%0d got %b want %b", c, bus.d_done, (c == 4));
      end
      nvec++;
      if (bus.if_done !== (c == 7)) begin
        nerr++; $display("FAIL simul_if_done c%0d got %b want %b", c, bus.if_done, (c == 7));
      end
      nvec++;
      if (bus.stall_mem !== (c <= 3)) begin
        nerr++; $display("FAIL simul_stall_mem c%0d got %b want %b", c, bus.stall_mem, (c <= 3));
      end
      nvec++;
      if (bus.stall_if !== (c <= 6)) begin
        nerr++; $display("FAIL simul_stall_if c%0d got %b want %b", c, bus.stall_if, (c <= 6));
      end
      if (c == 1) begin
        nvec++;
        if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin
          nerr++; $display("FAIL simul_first_grant got addr=%h we=%b want 00000100 0", bus.mem_addr, bus.mem_we);
        end
      end
      if (c == 4) begin
        nvec++;
        if (bus.mem_addr !== 32'h14) begin
          nerr++; $display("FAIL simul_second_addr got %h want 00000014", bus.mem_addr);
        end
        nvec++;
        if (bus.d_rdata !== 32'hC000_0100) begin
          nerr++; $display("FAIL simul_d_rdata got %h want c0000100", bus.d_rdata);
        end
      end
      if (c == 7) begin
        nvec++;
        if (bus.if_rdata !== 32'hC000_0014) begin
          nerr++; $display("FAIL simul_if_rdata got %h want c0000014", bus.if_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_store();
    for (int c = 0; c <= 5; c++) begin
      bus.d_req = (c <= 4); bus.d_we = 1'b1; bus.d_be = 4'b0011;
      bus.d_addr = 32'h104; bus.d_wdata = 32'h0000_c0de;
      #1;
      nvec++;
      if (bus.mem_en !== (c == 1)) begin
        nerr++; $display("FAIL store_mem_en c%0d got %b want %b", c, bus.mem_en, (c == 1));
      end
      nvec++;
      if (bus.d_done !== (c == 4)) begin
        nerr++; $display("FAIL store_d_done c%0d got %b want %b", c, bus.d_done, (c == 4));
      end
      if (c == 1) begin
        nvec++;
        if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 4'b0011, 32'h0000_0104, 32'h0000_c0de}) begin
          nerr++;
          $display("FAIL store_fields got we=%b be=%b addr=%h wdata=%h want 1 0011 00000104 0000c0de",
                   bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (c >= 4) begin
        nvec++;
        if (bus.d_rdata !== 32'hC000_0100) begin
          nerr++; $display("FAIL store_d_rdata_kept c%0d got %h want c0000100", c, bus.d_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c <= 8; c++) begin
      bus.if_req   = (c <= 1) || (c >= 3 && c <= 7);
      bus.if_addr  = (c <= 2) ? 32'h20 : 32'h40;
      bus.if_flush = (c == 2);
      #1;
      nvec++;
      if (bus.mem_en !== (c == 1 || c == 4)) begin
        nerr++; $display("FAIL flush_mem_en c%0d got %b want %b", c, bus.mem_en, (c == 1 || c == 4));
      end
      nvec++;
      if (bus.if_done !== (c == 7)) begin
        nerr++; $display("FAIL flush_if_done c%0d got %b want %b", c, bus.if_done, (c == 7));
      end
      if (c == 2) begin
        nvec++;
        if (bus.stall_if !== 1'b0) begin
          nerr++; $display("FAIL flush_stall_if got %b want 0", bus.stall_if);
        end
      end
      if (c == 4) begin
        nvec++;
        if (bus.mem_addr !== 32'h40) begin
          nerr++; $display("FAIL flush_refetch_addr got %h want 00000040", bus.mem_addr);
        end
        nvec++;
        if (bus.if_rdata !== 32'hC000_0014) begin
          nerr++; $display("FAIL flush_rdata_kept got %h want c0000014", bus.if_rdata);
        end
      end
      if (c == 7) begin
        nvec++;
        if (bus.if_rdata !== 32'hC000_0040) begin
          nerr++; $display("FAIL flush_if_rdata got %h want c0000040", bus.if_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_flush_at_capture();
    for (int c = 0; c <= 6; c++) begin
      bus.if_req   = (c <= 3);
      bus.if_addr  = 32'h30;
      bus.if_flush = (c == 3);
      #1;
      nvec++;
      if (bus.mem_en !== (c == 1)) begin
        nerr++; $display("FAIL late_flush_mem_en c%0d got %b want %b", c, bus.mem_en, (c == 1));
      end
      nvec++;
      if (bus.if_done !== 1'b0) begin
        nerr++; $display("FAIL late_flush_if_done c%0d got %b want 0", c, bus.if_done);
      end
      if (c == 5) begin
        nvec++;
        if (bus.if_rdata !== 32'hC000_0040) begin
          nerr++; $display("FAIL late_flush_rdata_kept got %h want c0000040", bus.if_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c <= 13; c++) begin
      rst = (c != 2);
      bus.d_req = (c <= 2) || (c >= 9); bus.d_we = 1'b0; bus.d_addr = 32'h108;
      #1;
      nvec++;
      if (bus.mem_en !== (c == 1 || c == 10)) begin
        nerr++; $display("FAIL midrst_mem_en c%0d got %b want %b", c, bus.mem_en, (c == 1 || c == 10));
      end
      nvec++;
      if (bus.d_done !== (c == 13)) begin
        nerr++; $display("FAIL midrst_d_done c%0d got %b want %b", c, bus.d_done, (c == 13));
      end
      if (c == 3) begin
        nvec++;
        if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.if_done,
             bus.d_done, bus.if_rdata, bus.d_rdata} !== '0) begin
          nerr++;
          $display("FAIL midrst_outputs got addr=%h be=%b ifr=%h dr=%h want all 0",
                   bus.mem_addr, bus.mem_be, bus.if_rdata, bus.d_rdata);
        end
      end
      if (c == 13) begin
        nvec++;
        if (bus.d_rdata !== 32'hC000_0108) begin
          nerr++; $display("FAIL midrst_d_rdata got %h want c0000108", bus.d_rdata);
        end
      end
      step();
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;
    test_reset();
    go_idle();
    test_fetch();
    go_idle();
    test_simultaneous();
    go_idle();
    test_store();
    go_idle();
    test_flush();
    go_idle();
    test_flush_at_capture();
    go_idle();
    test_mid_reset();
    go_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
